// File: rtl/rob_tag_allocator_pkg.sv
// ---------------------------------------------------------------------------
// rob_tag_allocator_pkg
//
// Shared types and constants for the reorder-buffer tag allocator slice.
//   ROB_ENTRIES : number of in-flight instruction ids (power of two)
//   ID_W        : id width, log2(ROB_ENTRIES)
//   NUM_REGS    : architectural register count
//   REG_W       : architectural register index width
//   rob_id_t    : an in-order instruction id
//   sb_entry_t  : one scoreboard slot {pending, producer id}
// ---------------------------------------------------------------------------
package rob_tag_allocator_pkg;

  localparam int ROB_ENTRIES = 8;
  localparam int ID_W        = $clog2(ROB_ENTRIES);
  localparam int NUM_REGS    = 32;
  localparam int REG_W       = 5;

  typedef logic [ID_W-1:0] rob_id_t;

  typedef struct packed {
    logic    pending;
    rob_id_t id;
  } sb_entry_t;

  // Ids wrap naturally because rob_id_t is exactly log2(ROB_ENTRIES) wide.
  function automatic rob_id_t nextId(rob_id_t cur);
    return cur + rob_id_t'(1);
  endfunction

endpackage

// File: rtl/rob_tag_allocator_scoreboard.sv
// ---------------------------------------------------------------------------
// rob_scoreboard
//
// Per-architectural-register producer table. Each slot records whether the
// register has an uncommitted producer and that producer's id.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   flush_i             : clear every pending bit on the next edge
//   alloc_en_i          : write {1, alloc_id_i} into slot alloc_reg_i
//   alloc_reg_i         : destination register of the allocating instruction
//   alloc_id_i          : id granted to the allocating instruction
//   clr_en_i            : retire request for slot clr_reg_i
//   clr_reg_i           : destination register of the retiring instruction
//   clr_id_i            : id of the retiring instruction
//   rd1_reg_i/rd2_reg_i : lookup registers
//   rd1_pending_o/...   : lookup results (id reads 0 when not pending)
// ---------------------------------------------------------------------------
module rob_scoreboard
  import rob_tag_allocator_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             alloc_en_i,
  input  logic [REG_W-1:0] alloc_reg_i,
  input  rob_id_t          alloc_id_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_reg_i,
  input  rob_id_t          clr_id_i,
  input  logic [REG_W-1:0] rd1_reg_i,
  input  logic [REG_W-1:0] rd2_reg_i,
  output logic             rd1_pending_o,
  output rob_id_t          rd1_id_o,
  output logic             rd2_pending_o,
  output rob_id_t          rd2_id_o
);

  sb_entry_t entries_q [NUM_REGS];
  sb_entry_t rd1Entry;
  sb_entry_t rd2Entry;

  // Slot 0 is never written. Allocation has priority over a retire of the
  // same register, and a retire only clears the slot if the recorded
  // producer is still the retiring instruction (a younger writer survives).
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        entries_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (alloc_en_i && (alloc_reg_i == REG_W'(r))) begin
          entries_q[r] <= '{pending: 1'b1, id: alloc_id_i};
        end else if (clr_en_i && (clr_reg_i == REG_W'(r)) &&
                     (entries_q[r].id == clr_id_i)) begin
          entries_q[r].pending <= 1'b0;
        end
      end
    end
  end

  // Lookups read only registered state; a same-cycle allocation is not
  // forwarded. A stale id is masked to 0 once the slot is no longer pending.
  always_comb begin
    rd1Entry = '0;
    rd2Entry = '0;
    if (rd1_reg_i != '0) rd1Entry = entries_q[rd1_reg_i];
    if (rd2_reg_i != '0) rd2Entry = entries_q[rd2_reg_i];
    rd1_pending_o = rd1Entry.pending;
    rd2_pending_o = rd2Entry.pending;
    rd1_id_o      = rd1Entry.pending ? rd1Entry.id : '0;
    rd2_id_o      = rd2Entry.pending ? rd2Entry.id : '0;
  end

endmodule

// File: rtl/rob_tag_allocator.sv
// ---------------------------------------------------------------------------
// rob_tag_allocator
//
// Issue-side companion of the reorder buffer: grants in-order instruction
// ids to decode, tracks occupancy until commit, and keeps a per-register
// producer scoreboard for the ALU/MUL bypass lookups. An exception flushes.
//
// Build option: ROB_ALLOC_CHECK_EN -- when defined, alloc_err latches on a
// commit while empty or a commit whose id is not the head, and simulation
// assertions are enabled. When undefined, alloc_err is tied low.
//
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   dec_req_valid / dec_req_ready   : id request handshake
//   dec_instr_id                    : granted id (tail pointer)
//   dec_writes_rf, dec_dest_reg     : destination of the allocating instr
//   dec_src1_reg, dec_src2_reg      : lookup registers
//   dec_src*_pending, dec_src*_id   : lookup results
//   commit_valid, commit_instr_id   : retire of the oldest instruction
//   commit_writes_rf, commit_dest_reg : destination of the retiring instr
//   xcpt_valid                      : flush request
//   rob_full, rob_empty, rob_oldest, rob_count : occupancy view
//   alloc_err                       : sticky protocol error
//
// ID_W must equal the package ID_W and ROB_ENTRIES must equal 2**ID_W; the
// scoreboard entries use the package id type.
// ---------------------------------------------------------------------------
module rob_tag_allocator #(
  parameter int ROB_ENTRIES = rob_tag_allocator_pkg::ROB_ENTRIES,
  parameter int ID_W        = rob_tag_allocator_pkg::ID_W,
  parameter int NUM_REGS    = rob_tag_allocator_pkg::NUM_REGS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            dec_req_valid,
  output logic            dec_req_ready,
  output logic [ID_W-1:0] dec_instr_id,
  input  logic            dec_writes_rf,
  input  logic [4:0]      dec_dest_reg,
  input  logic [4:0]      dec_src1_reg,
  input  logic [4:0]      dec_src2_reg,
  output logic            dec_src1_pending,
  output logic            dec_src2_pending,
  output logic [ID_W-1:0] dec_src1_id,
  output logic [ID_W-1:0] dec_src2_id,
  input  logic            commit_valid,
  input  logic [ID_W-1:0] commit_instr_id,
  input  logic            commit_writes_rf,
  input  logic [4:0]      commit_dest_reg,
  input  logic            xcpt_valid,
  output logic            rob_full,
  output logic            rob_empty,
  output logic [ID_W-1:0] rob_oldest,
  output logic [ID_W:0]   rob_count,
  output logic            alloc_err
);

  import rob_tag_allocator_pkg::*;

  // ROB_ENTRIES is a power of two, so "full" is just the top count bit.
  localparam logic [ID_W:0] FULL_COUNT = {1'b1, {ID_W{1'b0}}};

  logic [ID_W-1:0] head_q, head_d;
  logic [ID_W-1:0] tail_q, tail_d;
  logic [ID_W:0]   count_q, count_d;
  logic            allocFire;
  logic            commitFire;

  assign rob_full      = (count_q == FULL_COUNT);
  assign rob_empty     = (count_q == '0);
  assign rob_oldest    = head_q;
  assign rob_count     = count_q;
  assign dec_instr_id  = tail_q;
  assign dec_req_ready = ~rob_full & ~xcpt_valid;

  // A commit on an empty buffer or during a flush has no effect.
  assign allocFire  = dec_req_valid & dec_req_ready;
  assign commitFire = commit_valid & ~rob_empty & ~xcpt_valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (xcpt_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commitFire) head_d = nextId(head_q);
      if (allocFire)  tail_d = nextId(tail_q);
      case ({allocFire, commitFire})
        2'b10:   count_d = count_q + (ID_W+1)'(1);
        2'b01:   count_d = count_q - (ID_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  rob_scoreboard u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .flush_i       (xcpt_valid),
    .alloc_en_i    (allocFire & dec_writes_rf),
    .alloc_reg_i   (dec_dest_reg),
    .alloc_id_i    (tail_q),
    .clr_en_i      (commitFire & commit_writes_rf),
    .clr_reg_i     (commit_dest_reg),
    .clr_id_i      (commit_instr_id),
    .rd1_reg_i     (dec_src1_reg),
    .rd2_reg_i     (dec_src2_reg),
    .rd1_pending_o (dec_src1_pending),
    .rd1_id_o      (dec_src1_id),
    .rd2_pending_o (dec_src2_pending),
    .rd2_id_o      (dec_src2_id)
  );

`ifdef ROB_ALLOC_CHECK_EN
  logic errSet;
  logic err_q;

  // Commits ignored by a flush are not treated as protocol errors.
  assign errSet = commit_valid & ~xcpt_valid &
                  (rob_empty | (commit_instr_id != head_q));

  always_ff @(posedge clock) begin
    if (reset)       err_q <= 1'b0;
    else if (errSet) err_q <= 1'b1;
  end

  assign alloc_err = err_q;

  occupancyBound: assert property (@(posedge clock) disable iff (reset)
    count_q <= FULL_COUNT);
  noAllocWhenFull: assert property (@(posedge clock) disable iff (reset)
    rob_full |-> !allocFire);
`else
  assign alloc_err = 1'b0;
`endif

endmodule

// File: doc/rob_tag_allocator.md
# rob_tag_allocator

Issue-side counterpart of the reorder buffer. It hands out 3-bit in-order instruction ids to decoded instructions, and it tracks occupancy from allocation to commit. It also keeps a per-architectural-register scoreboard that supplies the producer ids driven into the ALU/MUL bypass lookups (`alu_src*_id`, `mul_src*_id`). It sits between decode and the execution stages, and frees entries on the write-back commit port. On an exception it flushes.

## Interface
Parameters:
- `ROB_ENTRIES`, default 8: number of in-flight ids; must be a power of two.
- `ID_W`, default 3: id width, equal to log2(`ROB_ENTRIES`).
- `NUM_REGS`, default 32: architectural registers; register 0 is never pending.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `dec_req_valid`  in  1  decode requests an id this cycle.
- `dec_req_ready`  out  1  an id is available; allocation happens on `valid & ready`.
- `dec_instr_id`  out  `ID_W`  id granted, equal to the tail pointer.
- `dec_writes_rf`  in  1  the allocating instruction writes the RF.
- `dec_dest_reg`  in  5  destination register of the allocating instruction.
- `dec_src1_reg`, `dec_src2_reg`  in  5 each  source registers to look up.
- `dec_src1_pending`, `dec_src2_pending`  out  1 each  the source has an uncommitted producer.
- `dec_src1_id`, `dec_src2_id`  out  `ID_W` each  producer id when pending; 0 otherwise.
- `commit_valid`  in  1  the write-back stage retires the oldest instruction.
- `commit_instr_id`  in  `ID_W`  id being retired.
- `commit_writes_rf`  in  1  the retiring instruction wrote the RF.
- `commit_dest_reg`  in  5  destination of the retiring instruction.
- `xcpt_valid`  in  1  exception flush request.
- `rob_full`, `rob_empty`  out  1 each  occupancy flags.
- `rob_oldest`  out  `ID_W`  head pointer.
- `rob_count`  out  `ID_W+1`  in-flight count.
- `alloc_err`  out  1  sticky protocol-error flag.

## Operation
- **State:**
  - head and tail pointers, each `ID_W` bits, wrapping modulo `ROB_ENTRIES`.
  - count, `ID_W+1` bits.
  - scoreboard of `NUM_REGS` entries, each {pending, id}.
- **Allocation.** When `dec_req_valid & dec_req_ready`:
  - tail increments and count increments.
  - If `dec_writes_rf` and `dec_dest_reg != 0`, scoreboard[dest] is set to {1, tail}.
- **Commit.** When `commit_valid` and not empty:
  - head increments and count decrements.
  - If `commit_writes_rf` and scoreboard[`commit_dest_reg`].id equals `commit_instr_id`, the pending bit clears. A younger producer that overwrote the entry is kept.
- **Simultaneous allocation and commit:**
  - count is unchanged.
  - When both target the same register, the allocation write wins.
- **Flush.** `xcpt_valid` clears head, tail, count and every pending bit on the next edge. `dec_req_ready` is 0 during the flush cycle, and any commit in that cycle is ignored.
- **Lookup** is combinational from the registered scoreboard. Register 0 always reads not-pending with id 0. There is no same-cycle bypass from an allocation.
- **`dec_req_ready`** is `!rob_full & !xcpt_valid`.

## Timing
- **Reset values:**
  - head = tail = count = 0.
  - `rob_empty` = 1, `rob_full` = 0, `rob_oldest` = 0, `dec_instr_id` = 0.
  - All pending bits 0; `alloc_err` = 0.
- **Latency:** the id is valid in the same cycle as the request. Pointers, count and scoreboard update at the next rising edge.
- **Full:** count equals `ROB_ENTRIES`, so `rob_full` = 1 and `dec_req_ready` = 0. A commit that cycle frees a slot for the next cycle only.
- **Empty:** a commit is ignored with no state change. With `ROB_ALLOC_CHECK_EN`, it also sets `alloc_err`.
- **Wrap-around:** after id 7, the tail returns to 0.
- **Reset mid-operation** has the same effect as a flush and also clears `alloc_err`.

## Configuration
- `ROB_ALLOC_CHECK_EN` defined: `alloc_err` is set and held until reset when either of these occurs:
  - a commit while empty;
  - `commit_instr_id != head`, i.e. an out-of-order retire.
  
  Simulation assertions are also enabled.
- Not defined: `alloc_err` is tied to 0, and the check logic is not synthesised.

## Structure
- The shared core package holds:
  - `ROB_ENTRIES` and `ID_W` constants;
  - the `rob_id_t` typedef;
  - the `sb_entry_t` struct {pending, id}.
- One sub-module, `rob_scoreboard`, contains the register table with its allocate, clear and flush ports and two read ports.
- Pointer and count logic lives in the top level.

## Test plan
- **Reset, then 8 back-to-back allocations:** ids 0..7 are granted; `rob_full` = 1 after the 8th; a 9th request sees `dec_req_ready` = 0.
- **Full, with commit id 0 and an allocation in the same cycle:** the allocation is refused that cycle. The next cycle grants id 0 (wrap) and count returns to 8.
- **Register reuse:** allocate r5 as id 2, then r5 again as id 3, then commit id 2. `dec_src1_reg` = 5 still reads pending with id 3. After committing id 3, it reads not-pending.
- **Flush with 5 in flight and `xcpt_valid` = 1:** the next cycle shows count 0, `rob_empty` = 1, no pending registers, and the next grant is id 0.
- **Destination r0:** allocate with `dec_dest_reg` = 0; a lookup of r0 reads not-pending.
- **`ROB_ALLOC_CHECK_EN`:** commit id 1 while the head is 0 → `alloc_err` rises the next cycle and stays high until reset.
